pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised inter-stage pipeline register for the MIPS pipeline. It is the generalised successor to the fixed per-stage registers: one instance can serve as IF/ID, ID/EX, EX/MEM or MEM/WB. It carries a control bundle and a data bundle under a valid/ready handshake, with a 2-entry skid buffer, synchronous flush, bubble control-gating and a saturating stall counter.

Parameters:
CTRL_W, 6, width of control bundle (Branch, MemRead, MemWrite, RegWrite, MemtoReg, Jump style bits).
DATA_W, 169, width of concatenated data bundle (targets, ALU result, operands, write-reg number, flags).
STAT_W, 16, width of stall counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
flush  input  1  synchronous squash of all held entries (branch/jump taken).
in_valid  input  1  upstream entry present.
in_ready  output  1  stage can accept; registered, equals !skid_valid.
in_ctrl  input  CTRL_W  upstream control bundle.
in_data  input  DATA_W  upstream data bundle.
out_valid  output  1  main entry valid.
out_ready  input  1  downstream accepts.
out_ctrl  output  CTRL_W  main control, forced all-zero when out_valid=0.
out_data  output  DATA_W  main data, not gated.
occupancy  output  2  entries held: 0, 1 or 2.
stall_cnt  output  STAT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Clock and reset: single clk domain. reset is asynchronous and active-high.
- Reset values: main/skid valid=0, main/skid ctrl=0, main/skid data=0, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Data is never combinationally passed from in_* to out_*.
- State EMPTY (occ 0):
  - in_fire: main<=in; go to ONE.
- State ONE (occ 1):
  - in_fire & out_fire: main<=in; stay ONE.
  - in_fire & !out_fire: skid<=in; go to TWO.
  - !in_fire & out_fire: go to EMPTY.
  - neither: hold.
- State TWO (occ 2):
  - in_ready=0.
  - out_fire: main<=skid; go to ONE.
  - otherwise hold.
- flush: highest priority after reset. Next state is EMPTY and both valids clear.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle is still consumed downstream; the entry is not repeated.
  - Data registers keep stale values; only the valids clear.
- Bubble gating: out_ctrl = main_ctrl when out_valid, else 0. A bubble never asserts RegWrite/MemWrite downstream.
- Ordering: entries leave strictly in arrival order. No loss and no duplication, except via flush.
- stall_cnt:
  - Increments in each cycle where out_valid & !out_ready.
  - Saturates at 2^STAT_W-1.
  - Cleared only by reset; not by flush.
- Async reset mid-transfer: outputs go to reset values immediately, without waiting for a clk edge. Release of reset must be glitch-free; the first in_fire is accepted on the first clk edge after deassertion.
- Widths: all bundles are pass-through, with no arithmetic. occupancy equals main_valid + skid_valid.

Test Plan:
- Reset check: assert reset asynchronously between edges with occ=2 -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cnt=0 before the next edge.
- Streaming: out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each; occupancy stays 1; in_ready always 1.
- Back-pressure: out_ready=0, push A=0x11, B=0x22 -> occupancy=2, in_ready=0, C held upstream. Then release out_ready -> out order A, B, C; stall_cnt equals the number of stalled cycles (e.g. 3).
- Flush with concurrent input: occupancy=2, in_valid=1, flush=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; that input never appears at the output.
- Bubble gating: in_ctrl=6'b111111, then idle -> out_ctrl=0x3F for exactly one cycle, then 0 while out_data still shows the last value.
- Counter saturation: STAT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt=15 and stays there; flush does not clear it.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Carries a control and a data bundle, supports synchronous flush and counts stalled cycles.
module pipe_stage_skid #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 169,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [STAT_W-1:0] stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid come straight from registers, so no in_* to out_* paths exist.

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [STAT_W-1:0] STALL_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STALL_MAX = {STAT_W{1'b1}};

  state_t            state;
  state_t            state_nx;
  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign main_valid = (state == ONE) || (state == TWO);
  assign skid_valid = (state == TWO);

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; flush overrides every transfer into the stage
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_nx = ONE;
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_nx = TWO;
          end else if (!in_fire && out_fire) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) state_nx = ONE;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Datapath load enables; a flushed cycle leaves the data registers stale
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: begin
          load_main_in = in_fire;
        end
        ONE: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        TWO: begin
          load_main_skid = out_fire;
        end
        default: begin
          load_main_in = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // Stall counter survives flush so stall statistics span squashes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
